regbank_write_arbiter: RTL

- Shares the single register-bank write port (rd_addr / write_data / reg_write) among NREQ writeback requesters, such as ALU, load unit and debug host.
- Each requester has a valid/ready handshake into a private one-entry holding buffer.
- A round-robin scheduler drains the buffers into the bank, one write per cycle.
- Exports a per-register pending mask so decode can stall on a register with a write still in flight.

---
 rtl/regbank_write_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regbank_write_arbiter.sv
// Purpose: shares one register-bank write port among NREQ requesters through per-requester one-entry buffers and a round-robin drain.
// Latency: 2 cycles minimum from request transfer to reg_write, NREQ+1 cycles worst case.
// Backpressure: req_ready[i] is low while buffer i is occupied, including the cycle it is granted, so there is no same-cycle refill.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready               per-requester handshake
//   req_addr/req_data                 packed per-requester address/data, requester i at [i*W +: W]
//   reg_write/rd_addr/write_data      registered bank write port
//   grant_id                          requester issued in the current reg_write cycle
//   pend_mask                         one bit per register with a buffered write outstanding
//   drop_r0                           one-cycle pulse when address-0 request(s) were discarded
module regbank_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 4,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 reg_write,
    output logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        write_data,
    output logic [1:0]           grant_id,
    output logic [2**AW-1:0]     pend_mask,
    output logic                 drop_r0
);

    localparam logic [1:0] PTR_LAST = 2'(NREQ - 1);

    logic [NREQ-1:0] buf_valid_q, buf_valid_d;
    logic [AW-1:0]   buf_addr_q [NREQ];
    logic [AW-1:0]   buf_addr_d [NREQ];
    logic [DW-1:0]   buf_data_q [NREQ];
    logic [DW-1:0]   buf_data_d [NREQ];
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   write_data_q, write_data_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic            drop_r0_q, drop_r0_d;

    logic            gnt_vld;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;

    // Round-robin search on buffer state only: start one past the last
    // winner and wrap, so the last winner has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr_q;
        cand    = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == PTR_LAST) ? 2'd0 : cand + 2'd1;
            if (!gnt_vld && buf_valid_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        drop_r0_d    = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = gnt_vld;
        rd_addr_d    = rd_addr_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;

        // Fill: a granted buffer is still valid this cycle, so it can never
        // be refilled at the same edge that drains it.
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !buf_valid_q[i]) begin
                if (req_addr[i*AW +: AW] == '0) begin
                    // Register 0 is hardwired: accept and discard.
                    drop_r0_d = 1'b1;
                end else begin
                    buf_valid_d[i] = 1'b1;
                    buf_addr_d[i]  = req_addr[i*AW +: AW];
                    buf_data_d[i]  = req_data[i*DW +: DW];
                end
            end
        end

        if (gnt_vld) begin
            buf_valid_d[gnt_idx] = 1'b0;
            rr_ptr_d             = gnt_idx;
            rd_addr_d            = buf_addr_q[gnt_idx];
            write_data_d         = buf_data_q[gnt_idx];
            grant_id_d           = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
            rr_ptr_q     <= PTR_LAST;
            reg_write_q  <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
            grant_id_q   <= 2'd0;
            drop_r0_q    <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            rr_ptr_q     <= rr_ptr_d;
            reg_write_q  <= reg_write_d;
            rd_addr_q    <= rd_addr_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
            drop_r0_q    <= drop_r0_d;
        end
    end

    // Pending bits come straight from buffer state, so an entry's bit drops
    // in the same cycle its reg_write is presented to the bank.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (buf_valid_q[i]) begin
                pend_mask[buf_addr_q[i]] = 1'b1;
            end
        end
    end

    assign req_ready  = ~buf_valid_q;
    assign reg_write  = reg_write_q;
    assign rd_addr    = rd_addr_q;
    assign write_data = write_data_q;
    assign grant_id   = grant_id_q;
    assign drop_r0    = drop_r0_q;

endmodule
